// File: rtl/mips.sv
// Five-stage pipelined RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq)
// with internal instruction/data memories, operand forwarding and hazard control.

module mips (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  reg_out_id,
    output logic [31:0] reg_out_data,
    input  logic        fetch_ram_load,
    input  logic        mem_ram_load
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        alu_op_t     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } ex_mem_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] if_pc, if_instr;
    logic [31:0] ifid_pc, ifid_instr;
    id_ex_t      id_ctrl, idex;
    ex_mem_t     exmem;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, take_branch;
    logic [31:0] branch_target;
    logic [31:0] rs1_val, rs2_val;
    logic        uses_rs1, uses_rs2;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_result;

    fetch_stage FETCH (
        .clock    (clock),
        .reset    (reset),
        .hold     (stall | fetch_ram_load),
        .redirect (take_branch),
        .target   (branch_target),
        .pc       (if_pc),
        .instr    (if_instr)
    );

    // A held IF/ID keeps the stalled instruction even while fetch is frozen.
    always_ff @(posedge clock) begin
        if (reset || take_branch) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP;
        end else if (stall) begin
            ifid_pc    <= ifid_pc;
            ifid_instr <= ifid_instr;
        end else if (fetch_ram_load) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP;
        end else begin
            ifid_pc    <= if_pc;
            ifid_instr <= if_instr;
        end
    end

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b;

    assign opcode = ifid_instr[6:0];
    assign funct3 = ifid_instr[14:12];
    assign funct7 = ifid_instr[31:25];
    assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                     ifid_instr[30:25], ifid_instr[11:8], 1'b0};

    register_file REGISTERS (
        .clock    (clock),
        .reset    (reset),
        .we       (wb_reg_write),
        .waddr    (wb_rd),
        .wdata    (wb_data),
        .raddr_a  (ifid_instr[19:15]),
        .raddr_b  (ifid_instr[24:20]),
        .dbg_addr (reg_out_id),
        .rdata_a  (rs1_val),
        .rdata_b  (rs2_val),
        .dbg_data (reg_out_data)
    );

    always_comb begin
        id_ctrl         = '0;
        uses_rs1        = 1'b0;
        uses_rs2        = 1'b0;
        id_ctrl.rd      = ifid_instr[11:7];
        id_ctrl.rs1     = ifid_instr[19:15];
        id_ctrl.rs2     = ifid_instr[24:20];
        id_ctrl.rs1_val = rs1_val;
        id_ctrl.rs2_val = rs2_val;
        id_ctrl.pc      = ifid_pc;
        case (opcode)
            7'b0110011: begin
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                id_ctrl.reg_write = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: id_ctrl.alu_op = ALU_ADD;
                    10'b0100000_000: id_ctrl.alu_op = ALU_SUB;
                    10'b0000000_111: id_ctrl.alu_op = ALU_AND;
                    10'b0000000_110: id_ctrl.alu_op = ALU_OR;
                    10'b0000000_010: id_ctrl.alu_op = ALU_SLT;
                    default: begin
                        uses_rs1          = 1'b0;
                        uses_rs2          = 1'b0;
                        id_ctrl.reg_write = 1'b0;
                    end
                endcase
            end
            7'b0010011: if (funct3 == 3'b000) begin
                uses_rs1          = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm       = imm_i;
            end
            7'b0000011: if (funct3 == 3'b010) begin
                uses_rs1          = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.mem_read  = 1'b1;
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm       = imm_i;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                id_ctrl.mem_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.imm       = imm_s;
            end
            7'b1100011: if (funct3 == 3'b000) begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                id_ctrl.branch = 1'b1;
                id_ctrl.imm    = imm_b;
            end
            default: ;
        endcase
    end

    assign stall = idex.mem_read && (idex.rd != 5'd0) &&
                   ((uses_rs1 && (id_ctrl.rs1 == idex.rd)) ||
                    (uses_rs2 && (id_ctrl.rs2 == idex.rd)));

    always_ff @(posedge clock) begin
        if (reset || take_branch || stall)
            idex <= '0;
        else
            idex <= id_ctrl;
    end

    // EX/MEM wins over MEM/WB; a load result is only available from MEM/WB.
    always_comb begin
        fwd_a = idex.rs1_val;
        fwd_b = idex.rs2_val;
        if (exmem.reg_write && !exmem.mem_read && exmem.rd != 5'd0 && exmem.rd == idex.rs1)
            fwd_a = exmem.alu_result;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == idex.rs1)
            fwd_a = wb_data;
        if (exmem.reg_write && !exmem.mem_read && exmem.rd != 5'd0 && exmem.rd == idex.rs2)
            fwd_b = exmem.alu_result;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == idex.rs2)
            fwd_b = wb_data;
    end

    assign alu_b = idex.alu_src ? idex.imm : fwd_b;

    always_comb begin
        case (idex.alu_op)
            ALU_ADD: alu_result = fwd_a + alu_b;
            ALU_SUB: alu_result = fwd_a - alu_b;
            ALU_AND: alu_result = fwd_a & alu_b;
            ALU_OR:  alu_result = fwd_a | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    assign take_branch   = idex.branch && (fwd_a == fwd_b);
    assign branch_target = idex.pc + idex.imm;

    always_ff @(posedge clock) begin
        if (reset)
            exmem <= '0;
        else
            exmem <= '{reg_write:  idex.reg_write,
                       mem_read:   idex.mem_read,
                       mem_write:  idex.mem_write,
                       rd:         idex.rd,
                       alu_result: alu_result,
                       store_data: fwd_b};
    end

    mem_stage MEM (
        .clock        (clock),
        .reset        (reset),
        .block_writes (mem_ram_load),
        .reg_write    (exmem.reg_write),
        .mem_read     (exmem.mem_read),
        .mem_write    (exmem.mem_write),
        .rd           (exmem.rd),
        .alu_result   (exmem.alu_result),
        .store_data   (exmem.store_data),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );
endmodule

module word_ram (
    input  logic        clock,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data
);
    logic [31:0] mem [0:255];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    // The write port stays idle in-system; programs are preloaded from outside.
    word_ram instruction_memory (
        .clock   (clock),
        .wr_en   (1'b0),
        .wr_addr (8'd0),
        .wr_data (32'd0),
        .rd_addr (pc[9:2]),
        .rd_data (instr)
    );

    always_ff @(posedge clock) begin
        if (reset)
            pc <= '0;
        else if (redirect)
            pc <= target;
        else if (!hold)
            pc <= pc + 32'd4;
    end
endmodule

module mem_access (
    input  logic        clock,
    input  logic        wr_en,
    input  logic [7:0]  word_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data
);
    word_ram data_memory (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (word_addr),
        .wr_data (wr_data),
        .rd_addr (word_addr),
        .rd_data (rd_data)
    );
endmodule

module mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        block_writes,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);
    logic [31:0] load_data;

    mem_access MEM_1 (
        .clock     (clock),
        .wr_en     (mem_write && !block_writes && !reset),
        .word_addr (alu_result[9:2]),
        .wr_data   (store_data),
        .rd_data   (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            wb_reg_write <= reg_write;
            wb_rd        <= rd;
            wb_data      <= mem_read ? load_data : alu_result;
        end
    end
endmodule

module register_file (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] dbg_data
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                registers[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end

    // Same-cycle write-back is passed straight through to the decode reads.
    assign rdata_a  = (raddr_a == 5'd0) ? 32'd0 :
                      (we && waddr == raddr_a) ? wdata : registers[raddr_a];
    assign rdata_b  = (raddr_b == 5'd0) ? 32'd0 :
                      (we && waddr == raddr_b) ? wdata : registers[raddr_b];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : registers[dbg_addr];
endmodule

// File: tb/tb_mips.sv
// Directed-program bench for the mips pipeline: loads small programs, runs a
// fixed number of cycles and compares registers/memory against hand values.

module tb_mips;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  reg_out_id = 5'd0;
    logic [31:0] reg_out_data;
    logic        fetch_ram_load = 1'b0;
    logic        mem_ram_load = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] prog [0:7];
    int          prog_len = 0;

    mips dut (
        .clock          (clock),
        .reset          (reset),
        .reg_out_id     (reg_out_id),
        .reg_out_data   (reg_out_data),
        .fetch_ram_load (fetch_ram_load),
        .mem_ram_load   (mem_ram_load)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, rs1, rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Clears instruction memory, loads prog[], then pulses reset for one cycle.
    task automatic applyStimulus();
        reset = 1'b1;
        for (int i = 0; i < 256; i++)
            dut.FETCH.instruction_memory.mem[i] <= (i < prog_len) ? prog[i] : 32'd0;
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic loadChain();
        prog[0] = enc_addi(5'd1, 5'd0, 12'd5);
        prog[1] = enc_r(7'b0000000, 3'b000, 5'd2, 5'd1, 5'd1);
        prog[2] = enc_r(7'b0100000, 3'b000, 5'd3, 5'd2, 5'd1);
        prog[3] = enc_r(7'b0000000, 3'b111, 5'd4, 5'd3, 5'd2);
        prog[4] = enc_r(7'b0000000, 3'b110, 5'd5, 5'd4, 5'd1);
        prog[5] = enc_r(7'b0000000, 3'b010, 5'd6, 5'd1, 5'd2);
        prog_len = 6;
    endtask

    task automatic checkChain(input string tag);
        checkOutput({tag, "_x2"}, dut.REGISTERS.registers[2], 32'd10);
        checkOutput({tag, "_x3"}, dut.REGISTERS.registers[3], 32'd5);
        checkOutput({tag, "_x4"}, dut.REGISTERS.registers[4], 32'd0);
        checkOutput({tag, "_x5"}, dut.REGISTERS.registers[5], 32'd5);
        checkOutput({tag, "_x6"}, dut.REGISTERS.registers[6], 32'd1);
    endtask

    initial begin
        int nonzero;

        runCycles(2);
        checkOutput("reset_pc", dut.FETCH.pc, 32'd0);
        checkOutput("reset_dbg_x0", reg_out_data, 32'd0);

        // Forwarding chain, debug port watching x3 change.
        loadChain();
        reg_out_id = 5'd3;
        applyStimulus();
        runCycles(6);
        checkOutput("dbg_x3_before", reg_out_data, 32'd0);
        runCycles(1);
        checkOutput("dbg_x3_after", reg_out_data, 32'd5);
        runCycles(2);
        checkOutput("chain_x6_early", dut.REGISTERS.registers[6], 32'd0);
        runCycles(1);
        checkChain("chain");

        // Reset mid-run, then re-execute the same program.
        applyStimulus();
        runCycles(5);
        checkOutput("midrst_x1_pre", dut.REGISTERS.registers[1], 32'd5);
        reset = 1'b1;
        runCycles(1);
        checkOutput("midrst_pc", dut.FETCH.pc, 32'd0);
        nonzero = 0;
        for (int i = 0; i < 32; i++)
            if (dut.REGISTERS.registers[i] != 32'd0) nonzero++;
        checkOutput("midrst_regs_nonzero", nonzero, 32'd0);
        reset = 1'b0;
        runCycles(10);
        checkChain("midrst");

        // Fetch freeze for 3 cycles delays completion by 3 cycles.
        applyStimulus();
        runCycles(2);
        checkOutput("freeze_pc_start", dut.FETCH.pc, 32'd8);
        fetch_ram_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runCycles(1);
            checkOutput("freeze_pc_held", dut.FETCH.pc, 32'd8);
        end
        fetch_ram_load = 1'b0;
        runCycles(7);
        checkOutput("freeze_x6_early", dut.REGISTERS.registers[6], 32'd0);
        runCycles(1);
        checkChain("freeze");

        // Load/store program with one load-use stall.
        prog[0] = enc_addi(5'd13, 5'd0, 12'd3);
        prog[1] = enc_addi(5'd14, 5'd0, 12'd0);
        prog[2] = enc_lw(5'd10, 5'd14, 12'd0);
        prog[3] = enc_lw(5'd11, 5'd14, 12'd4);
        prog[4] = enc_r(7'b0000000, 3'b000, 5'd12, 5'd11, 5'd10);
        prog[5] = enc_sw(5'd13, 5'd0, 12'd12);
        prog[6] = enc_sw(5'd12, 5'd0, 12'd8);
        prog_len = 7;
        dut.MEM.MEM_1.data_memory.mem[0] <= 32'd5;
        dut.MEM.MEM_1.data_memory.mem[1] <= 32'd7;
        dut.MEM.MEM_1.data_memory.mem[2] <= 32'd0;
        dut.MEM.MEM_1.data_memory.mem[3] <= 32'd0;
        applyStimulus();
        runCycles(10);
        checkOutput("ls_x12", dut.REGISTERS.registers[12], 32'd12);
        checkOutput("ls_dmem2_early", dut.MEM.MEM_1.data_memory.mem[2], 32'd0);
        runCycles(1);
        checkOutput("ls_dmem2", dut.MEM.MEM_1.data_memory.mem[2], 32'd12);
        checkOutput("ls_dmem3", dut.MEM.MEM_1.data_memory.mem[3], 32'd3);
        checkOutput("ls_x10", dut.REGISTERS.registers[10], 32'd5);
        checkOutput("ls_x11", dut.REGISTERS.registers[11], 32'd7);

        // Taken branch skips one instruction and costs 2 cycles.
        prog[0] = enc_addi(5'd1, 5'd0, 12'd1);
        prog[1] = enc_beq(5'd1, 5'd1, 13'd8);
        prog[2] = enc_addi(5'd2, 5'd0, 12'd9);
        prog[3] = enc_addi(5'd3, 5'd0, 12'd4);
        prog_len = 4;
        applyStimulus();
        runCycles(8);
        checkOutput("br_taken_x3_early", dut.REGISTERS.registers[3], 32'd0);
        runCycles(1);
        checkOutput("br_taken_x3", dut.REGISTERS.registers[3], 32'd4);
        checkOutput("br_taken_x2", dut.REGISTERS.registers[2], 32'd0);

        prog[1] = enc_beq(5'd1, 5'd0, 13'd8);
        applyStimulus();
        runCycles(8);
        checkOutput("br_nt_x2", dut.REGISTERS.registers[2], 32'd9);
        checkOutput("br_nt_x3", dut.REGISTERS.registers[3], 32'd4);

        // x0 stays zero and is never forwarded.
        prog[0] = enc_addi(5'd0, 5'd0, 12'd7);
        prog[1] = enc_r(7'b0000000, 3'b000, 5'd1, 5'd0, 5'd0);
        prog_len = 2;
        reg_out_id = 5'd0;
        applyStimulus();
        runCycles(6);
        checkOutput("x0_dbg", reg_out_data, 32'd0);
        checkOutput("x0_fwd_x1", dut.REGISTERS.registers[1], 32'd0);

        // Store gating by mem_ram_load, then the same store ungated.
        prog[0] = enc_addi(5'd1, 5'd0, 12'h021);
        prog[1] = enc_sw(5'd1, 5'd0, 12'd0);
        prog_len = 2;
        dut.MEM.MEM_1.data_memory.mem[0] <= 32'h55;
        mem_ram_load = 1'b1;
        applyStimulus();
        runCycles(6);
        checkOutput("gate_dmem0_blocked", dut.MEM.MEM_1.data_memory.mem[0], 32'h55);
        mem_ram_load = 1'b0;
        applyStimulus();
        runCycles(6);
        checkOutput("gate_dmem0_written", dut.MEM.MEM_1.data_memory.mem[0], 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
